hex_scan_mux: RTL

HEX_SCAN_MUX -- requirements
Module: hex_scan_mux

---
 rtl/seg_pkg.sv | 36 +++
 rtl/hex_scan_mux_scan_counter.sv | 40 ++++
 rtl/hex_scan_mux.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared types, constants and the leading-zero test for the scanner.
// Revision : 1.0
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [0:0] {
        ON  = 1'b0,
        GAP = 1'b1
    } scan_state_t;

    // Digit idx is a leading zero when it and every higher digit are zero
    // and none of them carries a decimal point; digit 0 always shows.
    function automatic logic lz_blanked(
        input logic [NUM_DIGITS*DIGIT_W-1:0] nibbles,
        input logic [NUM_DIGITS-1:0]         dp,
        input logic [IDX_W-1:0]              idx
    );
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx)) begin
                all_zero = all_zero && (nibbles[i*DIGIT_W +: DIGIT_W] == '0) && !dp[i];
            end
        end
        return (idx != '0) && all_zero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_mux_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : scan_counter
// Purpose  : Slot counter with separate ON/GAP lengths and a terminal count.
// Revision : 1.0
// ============================================================================
module scan_counter #(
    parameter int ON_LEN  = 4,
    parameter int OFF_LEN = 2,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_sel_on,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    localparam logic [CW-1:0] c_on_last  = CW'(ON_LEN - 1);
    localparam logic [CW-1:0] c_off_last = CW'(OFF_LEN - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_last;

    assign w_last  = i_sel_on ? c_on_last : c_off_last;
    assign o_tc    = (r_count == w_last);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_mux
// Purpose  : Four-digit hex display scanner with dead time, frame-atomic
//            updates and leading-zero blanking.
// Revision : 1.0
// ============================================================================
module hex_scan_mux
    import seg_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int GAP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  digit_nibble,
    output logic        digit_dp,
    output logic [3:0]  digit_en,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam int            c_cw     = $clog2((DIV > GAP) ? DIV : GAP);
    localparam logic [c_cw-1:0] c_on_pen = c_cw'(DIV - 2);

    seg_pkg::scan_state_t r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_first;
    logic [15:0]          r_shadow_val;
    logic [3:0]           r_shadow_dp;
    logic [15:0]          r_pend_val;
    logic [3:0]           r_pend_dp;
    logic                 r_pend_flag;
    logic [3:0]           r_nibble;
    logic                 r_dp;
    logic [3:0]           r_en;
    logic                 r_blank;
    logic                 r_frame_done;

    logic                 w_sel_on;
    logic [c_cw-1:0]      w_count;
    logic                 w_tc;
    logic                 w_enter_on;
    logic [IDX_W-1:0]     w_idx_nx;
    logic                 w_xfer;
    logic [15:0]          w_val_nx;
    logic [3:0]           w_dp_nx;
    seg_pkg::scan_state_t w_state_nx;
    logic                 w_blank_nx;
    logic                 w_fd_nx;

    scan_counter #(
        .ON_LEN  (DIV),
        .OFF_LEN (GAP),
        .CW      (c_cw)
    ) u_scan_counter (
        .clk      (clk),
        .rst      (reset),
        .i_sel_on (w_sel_on),
        .o_count  (w_count),
        .o_tc     (w_tc)
    );

    assign w_sel_on   = (r_state == seg_pkg::ON);
    assign w_enter_on = w_tc && (r_state == seg_pkg::GAP);
    // The first GAP after reset lands on digit 0 rather than advancing.
    assign w_idx_nx   = (w_enter_on && !r_first) ? r_idx + 1'b1 : r_idx;
    assign w_xfer     = w_enter_on && (w_idx_nx == '0) && r_pend_flag;
    assign w_val_nx   = w_xfer ? r_pend_val : r_shadow_val;
    assign w_dp_nx    = w_xfer ? r_pend_dp  : r_shadow_dp;
    assign w_state_nx = w_tc ? (w_sel_on ? seg_pkg::GAP : seg_pkg::ON) : r_state;
    assign w_blank_nx = blank_lz && lz_blanked(w_val_nx, w_dp_nx, w_idx_nx);
    // Outputs are registered, so the pulse is armed one cycle before the slot ends.
    assign w_fd_nx    = w_sel_on && !w_tc && (w_count == c_on_pen) && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= seg_pkg::GAP;
            r_idx        <= '0;
            r_first      <= 1'b1;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_flag  <= 1'b0;
            r_nibble     <= '0;
            r_dp         <= 1'b0;
            r_en         <= '0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_shadow_val <= w_val_nx;
            r_shadow_dp  <= w_dp_nx;
            r_frame_done <= w_fd_nx;
            if (w_enter_on) begin
                r_first <= 1'b0;
            end
            if (load) begin
                r_pend_val  <= value;
                r_pend_dp   <= dp_mask;
                r_pend_flag <= 1'b1;
            end else if (w_xfer) begin
                r_pend_flag <= 1'b0;
            end
            if (w_state_nx == seg_pkg::ON) begin
                r_en     <= w_blank_nx ? 4'b0000 : (4'b0001 << w_idx_nx);
                r_nibble <= w_val_nx[w_idx_nx*DIGIT_W +: DIGIT_W];
                r_dp     <= w_dp_nx[w_idx_nx];
                r_blank  <= w_blank_nx;
            end else begin
                r_en     <= 4'b0000;
                r_blank  <= 1'b1;
            end
        end
    end

    assign digit_nibble = r_nibble;
    assign digit_dp     = r_dp;
    assign digit_en     = r_en;
    assign digit_blank  = r_blank;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
